// File: rtl/decode_stage_pkg.sv
// bexkat1 decode definitions: instruction type and write-code enums, plus the
// partial-write merge shared by the register file and the decode bypass path.
package bexkat1Def;

    typedef enum logic [3:0] {
        T_INH    = 4'h0,
        T_PUSH   = 4'h1,
        T_POP    = 4'h2,
        T_CMP    = 4'h3,
        T_MOV    = 4'h4,
        T_INTU   = 4'h5,
        T_INT    = 4'h6,
        T_FPU    = 4'h7,
        T_FP     = 4'h8,
        T_ALU    = 4'h9,
        T_LOAD   = 4'ha,
        T_STORE  = 4'hb,
        T_LDI    = 4'hc,
        T_JUMP   = 4'hd,
        T_BRANCH = 4'he,
        T_RSVD   = 4'hf
    } instr_type_t;

    typedef enum logic [1:0] {
        WC_NONE = 2'd0,
        WC_B    = 2'd1,
        WC_H    = 2'd2,
        WC_W    = 2'd3
    } wcode_t;

    // Widest supported operand; callers widen/truncate around wc_merge.
    localparam int MERGE_W = 64;

    function automatic logic [MERGE_W-1:0] wc_merge(input logic [MERGE_W-1:0] old_v,
                                                    input logic [MERGE_W-1:0] new_v,
                                                    input wcode_t             code);
        logic [MERGE_W-1:0] r;
        r = old_v;
        case (code)
            WC_B:    r[7:0]  = new_v[7:0];
            WC_H:    r[15:0] = new_v[15:0];
            WC_W:    r       = new_v;
            default: r       = old_v;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/decode_stage_regfile.sv
// Architectural register file: two combinational reads, one synchronous write
// that merges byte/halfword/word per write code. Async active-high clear.
module decode_regfile
    import bexkat1Def::*;
#(
    parameter int DATA_W = 32,
    parameter int NREG   = 16,
    localparam int REG_AW = $clog2(NREG)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [REG_AW-1:0] rd1_addr_i,
    input  logic [REG_AW-1:0] rd2_addr_i,
    output logic [DATA_W-1:0] rd1_data_o,
    output logic [DATA_W-1:0] rd2_data_o,
    input  logic [1:0]        we_i,
    input  logic [REG_AW-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i
);

    logic [NREG-1:0][DATA_W-1:0] regs_q;
    logic [DATA_W-1:0]           wr_merged;

    assign rd1_data_o = regs_q[rd1_addr_i];
    assign rd2_data_o = regs_q[rd2_addr_i];

    assign wr_merged = DATA_W'(wc_merge(MERGE_W'(regs_q[wr_addr_i]),
                                        MERGE_W'(wr_data_i),
                                        wcode_t'(we_i)));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            regs_q <= '0;
        end else if (we_i != 2'd0) begin
            regs_q[wr_addr_i] <= wr_merged;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// bexkat1 decode stage: operand select/read, write-code decode, load-use hazard,
// flush/stall handling. Define DECODE_BYPASS_EN to forward same-cycle WB data.
module decode_stage
    import bexkat1Def::*;
#(
    parameter int DATA_W = 32,
    parameter int IR_W   = 64,
    parameter int PC_W   = 32,
    parameter int NREG   = 16,
    localparam int REG_AW = $clog2(NREG)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [IR_W-1:0]   ir_i,
    input  logic [PC_W-1:0]   pc_i,
    input  logic              valid_i,
    input  logic [3:0]        bank_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              ex_load_i,
    input  logic [REG_AW-1:0] ex_dest_i,
    input  logic [1:0]        wb_we_i,
    input  logic [REG_AW-1:0] wb_addr_i,
    input  logic [DATA_W-1:0] wb_data_i,
    output logic [IR_W-1:0]   ir_o,
    output logic [PC_W-1:0]   pc_o,
    output logic              valid_o,
    output logic [3:0]        bank_o,
    output logic [1:0]        reg_write_o,
    output logic [DATA_W-1:0] data1_o,
    output logic [DATA_W-1:0] data2_o,
    output logic              hazard_o
);

    instr_type_t       itype;
    logic [3:0]        op, ra_f, rb_f, rc_f;
    logic [REG_AW-1:0] r1, r2;
    logic              uses1, uses2;
    wcode_t            wc;
    logic [DATA_W-1:0] rf1, rf2, opnd1, opnd2;

    assign itype = instr_type_t'(ir_i[31:28]);
    assign op    = ir_i[27:24];
    assign ra_f  = ir_i[23:20];
    assign rb_f  = ir_i[19:16];
    assign rc_f  = ir_i[15:12];

    always_comb begin
        r1    = rb_f[REG_AW-1:0];
        r2    = rc_f[REG_AW-1:0];
        uses1 = 1'b1;
        uses2 = 1'b1;
        wc    = WC_NONE;
        case (itype)
            T_INTU:                r2 = rb_f[REG_AW-1:0];
            T_CMP, T_STORE, T_LOAD: begin
                r1 = ra_f[REG_AW-1:0];
                r2 = rb_f[REG_AW-1:0];
            end
            default: ;
        endcase
        case (itype)
            T_LDI, T_JUMP, T_BRANCH, T_INH: begin
                uses1 = 1'b0;
                uses2 = 1'b0;
            end
            default: ;
        endcase
        case (itype)
            T_INTU, T_INT, T_LDI, T_LOAD, T_ALU: wc = WC_W;
            T_MOV:   wc = (op == 4'd0) ? WC_W : wcode_t'(op[1:0]);
            default: wc = WC_NONE;
        endcase
    end

    assign hazard_o = valid_i & ex_load_i &
                      ((uses1 & (r1 == ex_dest_i)) | (uses2 & (r2 == ex_dest_i)));

    decode_regfile #(.DATA_W(DATA_W), .NREG(NREG)) u_regfile (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .rd1_addr_i (r1),
        .rd2_addr_i (r2),
        .rd1_data_o (rf1),
        .rd2_data_o (rf2),
        .we_i       (wb_we_i),
        .wr_addr_i  (wb_addr_i),
        .wr_data_i  (wb_data_i)
    );

`ifdef DECODE_BYPASS_EN
    logic [DATA_W-1:0] wb1_merged, wb2_merged;
    assign wb1_merged = DATA_W'(wc_merge(MERGE_W'(rf1), MERGE_W'(wb_data_i), wcode_t'(wb_we_i)));
    assign wb2_merged = DATA_W'(wc_merge(MERGE_W'(rf2), MERGE_W'(wb_data_i), wcode_t'(wb_we_i)));
    assign opnd1 = (wb_we_i != 2'd0 && wb_addr_i == r1) ? wb1_merged : rf1;
    assign opnd2 = (wb_we_i != 2'd0 && wb_addr_i == r2) ? wb2_merged : rf2;
`else
    assign opnd1 = rf1;
    assign opnd2 = rf2;
`endif

    logic [IR_W-1:0]   ir_q, ir_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              valid_q, valid_d;
    logic [3:0]        bank_q, bank_d;
    logic [1:0]        rw_q, rw_d;
    logic [DATA_W-1:0] d1_q, d1_d, d2_q, d2_d;

    // flush > stall > hazard > normal; bubbles still latch PC/bank/data (don't-care).
    always_comb begin
        ir_d    = ir_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        bank_d  = bank_q;
        rw_d    = rw_q;
        d1_d    = d1_q;
        d2_d    = d2_q;
        if (flush_i || (!stall_i)) begin
            pc_d   = pc_i;
            bank_d = bank_i;
            d1_d   = opnd1;
            d2_d   = opnd2;
            if (flush_i || hazard_o) begin
                ir_d    = '0;
                valid_d = 1'b0;
                rw_d    = 2'd0;
            end else begin
                ir_d    = ir_i;
                valid_d = valid_i;
                rw_d    = valid_i ? wc : WC_NONE;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ir_q    <= '0;
            pc_q    <= '0;
            valid_q <= 1'b0;
            bank_q  <= '0;
            rw_q    <= '0;
            d1_q    <= '0;
            d2_q    <= '0;
        end else begin
            ir_q    <= ir_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            bank_q  <= bank_d;
            rw_q    <= rw_d;
            d1_q    <= d1_d;
            d2_q    <= d2_d;
        end
    end

    assign ir_o        = ir_q;
    assign pc_o        = pc_q;
    assign valid_o     = valid_q;
    assign bank_o      = bank_q;
    assign reg_write_o = rw_q;
    assign data1_o     = d1_q;
    assign data2_o     = d2_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: reset, regfile write/merge, decode fields,
// load-use hazard, stall/flush priority and same-cycle WB read behaviour.
module tb_decode_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [63:0] ir_i;
    logic [31:0] pc_i;
    logic        valid_i;
    logic [3:0]  bank_i;
    logic        stall_i, flush_i, ex_load_i;
    logic [3:0]  ex_dest_i;
    logic [1:0]  wb_we_i;
    logic [3:0]  wb_addr_i;
    logic [31:0] wb_data_i;
    logic [63:0] ir_o;
    logic [31:0] pc_o;
    logic        valid_o;
    logic [3:0]  bank_o;
    logic [1:0]  reg_write_o;
    logic [31:0] data1_o, data2_o;
    logic        hazard_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    decode_stage dut (
        .clk_i(clk_i), .rst_i(rst_i), .ir_i(ir_i), .pc_i(pc_i), .valid_i(valid_i),
        .bank_i(bank_i), .stall_i(stall_i), .flush_i(flush_i), .ex_load_i(ex_load_i),
        .ex_dest_i(ex_dest_i), .wb_we_i(wb_we_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
        .ir_o(ir_o), .pc_o(pc_o), .valid_o(valid_o), .bank_o(bank_o),
        .reg_write_o(reg_write_o), .data1_o(data1_o), .data2_o(data2_o), .hazard_o(hazard_o)
    );

    function automatic logic [63:0] mk(input logic [3:0] t, input logic [3:0] op,
                                       input logic [3:0] ra, input logic [3:0] rb,
                                       input logic [3:0] rc);
        return {32'h0, t, op, ra, rb, rc, 12'h0};
    endfunction

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic idle();
        ir_i = '0; pc_i = '0; valid_i = 0; bank_i = '0; stall_i = 0; flush_i = 0;
        ex_load_i = 0; ex_dest_i = '0; wb_we_i = '0; wb_addr_i = '0; wb_data_i = '0;
    endtask

    task automatic wb(input logic [3:0] a, input logic [1:0] c, input logic [31:0] d);
        idle();
        wb_addr_i = a; wb_we_i = c; wb_data_i = d;
        step();
        wb_we_i = '0;
    endtask

    task automatic test_reset();
        idle();
        rst_i = 1;
        #12;
        @(negedge clk_i);
        rst_i = 0;
        wb(4'd5, 2'd3, 32'h0BAD_F00D);
        ir_i = mk(4'h9, 4'h0, 4'h1, 4'h5, 4'h5); pc_i = 32'h44; valid_i = 1; bank_i = 4'h7;
        step();
        checks++;
        if (data1_o !== 32'h0BAD_F00D || valid_o !== 1'b1) begin
            errors++; $display("FAIL pre_reset d1=%h v=%b want 0badf00d 1", data1_o, valid_o);
        end
        valid_i = 0;
        #3 rst_i = 1;
        #1;
        checks++;
        if ({ir_o, pc_o, valid_o, bank_o, reg_write_o, data1_o, data2_o, hazard_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs ir=%h pc=%h v=%b bank=%h rw=%h d1=%h d2=%h hz=%b want all 0",
                     ir_o, pc_o, valid_o, bank_o, reg_write_o, data1_o, data2_o, hazard_o);
        end
        @(negedge clk_i);
        rst_i = 0;
        idle();
        ir_i = mk(4'h9, 4'h0, 4'h1, 4'h5, 4'h5); valid_i = 1;
        step();
        checks++;
        if (data1_o !== 32'h0 || data2_o !== 32'h0) begin
            errors++; $display("FAIL reset_r5 d1=%h d2=%h want 0", data1_o, data2_o);
        end
    endtask

    task automatic test_wb_read();
        wb(4'd3, 2'd3, 32'hDEADBEEF);
        ir_i = mk(4'h9, 4'h2, 4'h1, 4'h3, 4'h3); pc_i = 32'h100; valid_i = 1; bank_i = 4'h3;
        step();
        checks++;
        if (data1_o !== 32'hDEADBEEF || data2_o !== 32'hDEADBEEF || reg_write_o !== 2'd3 ||
            valid_o !== 1'b1 || pc_o !== 32'h100 || bank_o !== 4'h3 ||
            ir_o !== mk(4'h9, 4'h2, 4'h1, 4'h3, 4'h3)) begin
            errors++;
            $display("FAIL wb_read d1=%h d2=%h rw=%0d v=%b pc=%h bank=%h want deadbeef deadbeef 3 1 100 3",
                     data1_o, data2_o, reg_write_o, valid_o, pc_o, bank_o);
        end
    endtask

    task automatic test_merge();
        wb(4'd4, 2'd3, 32'h11223344);
        wb(4'd4, 2'd1, 32'h000000FF);
        ir_i = mk(4'h9, 4'h0, 4'h0, 4'h4, 4'h4); valid_i = 1;
        step();
        checks++;
        if (data1_o !== 32'h112233FF) begin
            errors++; $display("FAIL merge_byte got=%h want 112233ff", data1_o);
        end
        wb(4'd4, 2'd2, 32'h0000AAAA);
        ir_i = mk(4'h9, 4'h0, 4'h0, 4'h4, 4'h4); valid_i = 1;
        step();
        checks++;
        if (data1_o !== 32'h1122AAAA) begin
            errors++; $display("FAIL merge_half got=%h want 1122aaaa", data1_o);
        end
    endtask

    task automatic test_decode();
        // INTU reads rb twice; rc ignored
        idle();
        ir_i = mk(4'h5, 4'h0, 4'h1, 4'h3, 4'h4); valid_i = 1;
        step();
        checks++;
        if (data1_o !== 32'hDEADBEEF || data2_o !== 32'hDEADBEEF || reg_write_o !== 2'd3) begin
            errors++; $display("FAIL intu d1=%h d2=%h rw=%0d want deadbeef deadbeef 3", data1_o, data2_o, reg_write_o);
        end
        ir_i = mk(4'hb, 4'h0, 4'h3, 4'h4, 4'h5);
        step();
        checks++;
        if (data1_o !== 32'hDEADBEEF || data2_o !== 32'h1122AAAA || reg_write_o !== 2'd0) begin
            errors++; $display("FAIL store d1=%h d2=%h rw=%0d want deadbeef 1122aaaa 0", data1_o, data2_o, reg_write_o);
        end
        ir_i = mk(4'h4, 4'h2, 4'h1, 4'h3, 4'h0);
        step();
        checks++;
        if (reg_write_o !== 2'd2) begin
            errors++; $display("FAIL mov_h rw=%0d want 2", reg_write_o);
        end
        ir_i = mk(4'h4, 4'h0, 4'h1, 4'h3, 4'h0);
        step();
        checks++;
        if (reg_write_o !== 2'd3) begin
            errors++; $display("FAIL mov0 rw=%0d want 3", reg_write_o);
        end
        ir_i = mk(4'h9, 4'h0, 4'h1, 4'h3, 4'h3); valid_i = 0;
        step();
        checks++;
        if (reg_write_o !== 2'd0 || valid_o !== 1'b0) begin
            errors++; $display("FAIL invalid_rw rw=%0d v=%b want 0 0", reg_write_o, valid_o);
        end
    endtask

    task automatic test_hazard();
        idle();
        ex_load_i = 1; ex_dest_i = 4'd2;
        ir_i = mk(4'h3, 4'h0, 4'h2, 4'h0, 4'h0); pc_i = 32'h300; valid_i = 1;
        #1;
        checks++;
        if (hazard_o !== 1'b1) begin
            errors++; $display("FAIL hazard_cmp got=%b want 1", hazard_o);
        end
        step();
        checks++;
        if (valid_o !== 1'b0 || reg_write_o !== 2'd0 || ir_o !== 64'h0) begin
            errors++; $display("FAIL hazard_bubble v=%b rw=%0d ir=%h want 0 0 0", valid_o, reg_write_o, ir_o);
        end
        ex_load_i = 0;
        #1;
        checks++;
        if (hazard_o !== 1'b0) begin
            errors++; $display("FAIL hazard_clear got=%b want 0", hazard_o);
        end
        step();
        checks++;
        if (valid_o !== 1'b1 || ir_o !== mk(4'h3, 4'h0, 4'h2, 4'h0, 4'h0) || pc_o !== 32'h300) begin
            errors++; $display("FAIL hazard_issue v=%b ir=%h pc=%h want 1 cmp 300", valid_o, ir_o, pc_o);
        end
        // LDI consumes no operand; invalid slot never raises hazard
        ex_load_i = 1; ex_dest_i = 4'd2;
        ir_i = mk(4'hc, 4'h0, 4'h2, 4'h2, 4'h2);
        #1;
        checks++;
        if (hazard_o !== 1'b0) begin
            errors++; $display("FAIL hazard_ldi got=%b want 0", hazard_o);
        end
        ir_i = mk(4'h9, 4'h0, 4'h1, 4'h2, 4'h2); valid_i = 0;
        #1;
        checks++;
        if (hazard_o !== 1'b0) begin
            errors++; $display("FAIL hazard_invalid got=%b want 0", hazard_o);
        end
        ex_load_i = 0;
    endtask

    task automatic test_stall_flush();
        idle();
        ir_i = mk(4'h9, 4'h1, 4'h1, 4'h3, 4'h4); pc_i = 32'h200; valid_i = 1; bank_i = 4'h9;
        step();
        stall_i = 1;
        for (int i = 0; i < 2; i++) begin
            ir_i = mk(4'h4, 4'(i + 1), 4'h2, 4'h4, 4'h3); pc_i = 32'h210 + 32'(i); bank_i = 4'h1;
            step();
            checks++;
            if (ir_o !== mk(4'h9, 4'h1, 4'h1, 4'h3, 4'h4) || pc_o !== 32'h200 || valid_o !== 1'b1 ||
                bank_o !== 4'h9 || reg_write_o !== 2'd3 || data1_o !== 32'hDEADBEEF ||
                data2_o !== 32'h1122AAAA) begin
                errors++;
                $display("FAIL stall_hold%0d ir=%h pc=%h v=%b bank=%h rw=%0d want held values",
                         i, ir_o, pc_o, valid_o, bank_o, reg_write_o);
            end
        end
        flush_i = 1;
        step();
        checks++;
        if (valid_o !== 1'b0 || reg_write_o !== 2'd0 || ir_o !== 64'h0) begin
            errors++; $display("FAIL flush_stall v=%b rw=%0d ir=%h want 0 0 0", valid_o, reg_write_o, ir_o);
        end
        idle();
    endtask

    task automatic test_bypass();
        logic [31:0] exp1;
        wb(4'd7, 2'd3, 32'h1);
`ifdef DECODE_BYPASS_EN
        exp1 = 32'h5;
`else
        exp1 = 32'h1;
`endif
        wb_addr_i = 4'd7; wb_we_i = 2'd3; wb_data_i = 32'h5;
        ir_i = mk(4'h9, 4'h0, 4'h1, 4'h7, 4'h0); valid_i = 1;
        step();
        checks++;
        if (data1_o !== exp1 || data2_o !== 32'h0) begin
            errors++; $display("FAIL same_cycle_wb d1=%h d2=%h want %h 0", data1_o, data2_o, exp1);
        end
        wb_we_i = '0;
        step();
        checks++;
        if (data1_o !== 32'h5) begin
            errors++; $display("FAIL wb_after d1=%h want 5", data1_o);
        end
    endtask

    initial begin
        test_reset();
        test_wb_read();
        test_merge();
        test_decode();
        test_hazard();
        test_stall_flush();
        test_bypass();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
